// File: rtl/modred_sched_pkg.sv
// Shared constants and types for the modular-reduction scheduler.
//   LATENCY_DEF : default pipeline latency of the external reduction unit
//   OPND_W      : product (operand) width fed to the pipeline
//   RES_W       : residue / modulus width
//   Q_BENCH     : reference modulus (6*2^11+1) used by benches
package modred_sched_pkg;

  localparam int LATENCY_DEF = 5;
  localparam int OPND_W      = 32;
  localparam int RES_W       = 16;

  localparam logic [RES_W-1:0] Q_BENCH = 16'd12289;

  typedef logic [OPND_W-1:0] opnd_t;
  typedef logic [RES_W-1:0]  res_t;

endpackage

// File: rtl/modred_sched_if.sv
// Bus bundle between the scheduler, its requesters, the external reduction
// pipeline and the response consumer.
//   req_valid/req_data/req_ready : per-requester issue handshake
//   mr_q/mr_p/mr_c               : modulus, operand and result of the pipeline
//   rsp_valid/rsp_ready/rsp_id/rsp_data : buffered result stream
// slave = scheduler side, master = environment side.
interface modred_sched_if #(
  parameter int NUM_REQ = 4
);
  import modred_sched_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [OPND_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  res_t                      mr_q;
  opnd_t                     mr_p;
  res_t                      mr_c;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  res_t                      rsp_data;

  modport slave (
    input  req_valid, req_data, mr_c, rsp_ready,
    output req_ready, mr_q, mr_p, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_data, mr_c, rsp_ready,
    input  req_ready, mr_q, mr_p, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/modred_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ (power of two).
//   req_i : request vector
//   ptr_i : search start index
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : encoded grant index
//   any_o : some request granted
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] cand;

  // Scan from the farthest offset back to ptr_i so the candidate closest to
  // the pointer is the last one written and therefore wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + ID_W'(k);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modred_sched.sv
// Shares one fixed-latency modular-reduction pipeline among NUM_REQ
// requesters. Issues are round-robin arbitrated and credit-limited so the
// result FIFO can never overflow and the pipeline never stalls.
//   clk, reset         : clock, async active-high reset
//   cfg_we_i, cfg_q_i  : modulus load, accepted only while idle
//   busy_o             : any op in flight or buffered
//   bus_if (slave)     : requester, pipeline and response signals
module modred_sched
  import modred_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = LATENCY_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we_i,
  input  res_t          cfg_q_i,
  output logic          busy_o,
  modred_sched_if.slave bus_if
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  logic [CW-1:0]   credits_q, credits_d;
  logic [CW-1:0]   count_q, count_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  res_t            mr_q_q, mr_q_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0] tag_id_q [LATENCY];
  logic [ID_W-1:0] fifo_id_q [FIFO_DEPTH];
  res_t            fifo_data_q [FIFO_DEPTH];

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic               can_issue, issue, push, pop, fifo_vld;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (bus_if.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Reset term keeps req_ready low while reset is held even though the
  // credit counter already sits at its full value.
  assign can_issue = (credits_q != '0) && !reset;
  assign issue     = arb_any && can_issue;
  assign push      = tag_vld_q[LATENCY-1];
  assign fifo_vld  = (count_q != '0);
  assign pop       = fifo_vld && bus_if.rsp_ready;
  assign busy_o    = (credits_q != CRED_MAX);

  assign bus_if.req_ready = arb_gnt & {NUM_REQ{can_issue}};
  assign bus_if.mr_p      = issue ? bus_if.req_data[int'(arb_idx)*OPND_W +: OPND_W] : '0;
  assign bus_if.mr_q      = mr_q_q;
  assign bus_if.rsp_valid = fifo_vld;
  // FIFO storage is not reset, so the head is masked while empty.
  assign bus_if.rsp_id    = fifo_vld ? fifo_id_q[rd_ptr_q] : '0;
  assign bus_if.rsp_data  = fifo_vld ? fifo_data_q[rd_ptr_q] : '0;

  always_comb begin
    credits_d = credits_q;
    if (issue && !pop) credits_d = credits_q - CW'(1);
    else if (!issue && pop) credits_d = credits_q + CW'(1);
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    ptr_d  = issue ? arb_idx + ID_W'(1) : ptr_q;
    mr_q_d = (cfg_we_i && !busy_o) ? cfg_q_i : mr_q_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q <= CRED_MAX;
      count_q   <= '0;
      ptr_q     <= '0;
      mr_q_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_vld_q <= '0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      mr_q_q    <= mr_q_d;
      tag_vld_q <= {tag_vld_q[LATENCY-2:0], issue};
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Tag ids and FIFO payload are qualified by valids/count, so no reset.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= arb_idx;
    for (int i = 1; i < LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
    if (push) begin
      fifo_id_q[wr_ptr_q]   <= tag_id_q[LATENCY-1];
      fifo_data_q[wr_ptr_q] <= bus_if.mr_c;
    end
  end

endmodule

// File: tb/tb_modred_sched.sv
// Bench for modred_sched: a transaction-level model predicts arbitration,
// credits, FIFO occupancy and modulus; expected responses are queued at issue
// and a separate monitor compares them as the DUT delivers results.
module tb_modred_sched;
  import modred_sched_pkg::*;

  localparam int N     = 4;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_q = '0;
  logic        busy;

  modred_sched_if #(.NUM_REQ(N)) bus ();

  modred_sched #(.NUM_REQ(N), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we_i (cfg_we),
    .cfg_q_i  (cfg_q),
    .busy_o   (busy),
    .bus_if   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mod(input logic [31:0] p, input logic [15:0] q);
    if (q == 16'd0) return 16'd0;
    return 16'(p % {16'd0, q});
  endfunction

  // External reduction pipeline: LAT register stages behind mr_p/mr_q.
  logic [15:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= ref_mod(bus.mr_p, bus.mr_q);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mr_c = pipe[LAT-1];

  typedef struct {int id; logic [15:0] data;} exp_t;
  exp_t sb[$];
  int   infl[$];

  int n_total = 0;
  int n_pass  = 0;
  int m_ptr, m_cred, m_fifo, cyc, last_g, dut_iss_cnt;
  bit m_issued;
  logic [15:0] m_q;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: inputs were set at the preceding negedge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [31:0]  pd;
    int g;
    bit pop;
    #1;
    m_issued = 1'b0;
    if (reset) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mr_q", bus.mr_q, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      m_ptr = 0; m_cred = DEPTH; m_fifo = 0; m_q = '0;
      infl.delete();
      sb.delete();
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_rdy = '0;
      pd = '0;
      if (g >= 0 && m_cred != 0) begin
        m_issued = 1'b1;
        exp_rdy[g] = 1'b1;
        pd = bus.req_data[g*32 +: 32];
      end
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("mr_p", bus.mr_p, pd);
      chk("rsp_valid", bus.rsp_valid, m_fifo != 0);
      chk("busy", busy, m_cred != DEPTH);
      chk("mr_q", bus.mr_q, m_q);
      if ((bus.req_ready & bus.req_valid) != '0) dut_iss_cnt++;
      pop = (m_fifo != 0) && bus.rsp_ready;
      if (cfg_we && m_cred == DEPTH) m_q = cfg_q;
      if (m_issued) begin
        sb.push_back('{id: g, data: ref_mod(pd, bus.mr_q)});
        infl.push_back(cyc + LAT);
        m_ptr = (g + 1) % N;
        m_cred--;
        last_g = g;
      end
      if (infl.size() > 0 && infl[0] == cyc) begin
        void'(infl.pop_front());
        m_fifo++;
      end
      if (pop) begin
        m_fifo--;
        m_cred++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic all_valid();
    for (int i = 0; i < N; i++) set_req(i, $urandom());
  endtask

  // Accepted requester presents a fresh operand.
  task automatic refresh();
    if (m_issued) bus.req_data[last_g*32 +: 32] = $urandom();
  endtask

  // Response monitor / scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got id %0d data %0d, expected no response", bus.rsp_id, bus.rsp_data);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_data", bus.rsp_data, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, base, k;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    cyc = 0; dut_iss_cnt = 0; last_g = 0; m_issued = 1'b0;
    @(negedge clk);
    repeat (3) step();
    reset = 1'b0;
    step();

    // Modulus load while idle.
    cfg_we = 1'b1; cfg_q = Q_BENCH;
    step();
    cfg_we = 1'b0;
    chk("cfg_load", bus.mr_q, 12289);

    // Single requester 2, P=0: six-cycle request-to-response latency.
    bus.rsp_ready = 1'b1;
    set_req(2, 32'd0);
    step();
    bus.req_valid = '0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin step(); lat++; end
    chk("latency", lat, LAT + 1);
    repeat (2) step();

    // Nonzero operand, then a modulus write while busy must be ignored.
    set_req(2, 32'h89AB_CDEF);
    step();
    bus.req_valid = '0;
    cfg_we = 1'b1; cfg_q = 16'd7681;
    step();
    cfg_we = 1'b0;
    chk("cfg_ignored_busy", bus.mr_q, 12289);
    repeat (8) step();

    // All requesters continuously valid: one grant per cycle, rotating.
    all_valid();
    repeat (16) begin step(); refresh(); end
    bus.req_valid = '0;
    repeat (8) step();

    // Back-pressure: exactly DEPTH issues, then one per pop.
    bus.rsp_ready = 1'b0;
    all_valid();
    base = dut_iss_cnt;
    repeat (14) begin step(); refresh(); end
    chk("bp_issue_limit", dut_iss_cnt - base, DEPTH);
    chk("bp_busy", busy, 1);
    bus.rsp_ready = 1'b1;
    step();
    refresh();
    bus.rsp_ready = 1'b0;
    base = dut_iss_cnt;
    repeat (10) begin step(); refresh(); end
    chk("bp_one_more", dut_iss_cnt - base, 1);
    chk("bp_busy_full", busy, 1);

    // From a full FIFO: concurrent issue/push/pop at high occupancy.
    bus.rsp_ready = 1'b1;
    repeat (20) begin step(); refresh(); end
    bus.req_valid = '0;
    k = 0;
    while (busy && k < 40) begin step(); k++; end
    chk("drained_busy", busy, 0);

    // Randomised traffic with occasional drops, stalls and cfg attempts.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, $urandom());
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 19) == 0);
      cfg_q  = ($urandom_range(0, 1) == 0) ? 16'd7681 : Q_BENCH;
      step();
      if (m_issued) bus.req_valid[last_g] = 1'b0;
    end
    cfg_we = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    k = 0;
    while (busy && k < 40) begin step(); k++; end
    chk("rand_drained", busy, 0);

    // Reset with 3 ops in flight and 2 in the FIFO.
    bus.rsp_ready = 1'b0;
    all_valid();
    repeat (5) begin step(); refresh(); end
    bus.req_valid = '0;
    repeat (2) step();
    chk("pre_reset_rsp_valid", bus.rsp_valid, 1);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    bus.req_valid = '1;
    step();
    bus.req_valid = '0;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (12) step();
    chk("post_reset_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
